// File: rtl/ham_rx_deserializer_if.sv
// Serial codeword input and parallel message output bundle for ham_rx_deserializer.
// master drives bits and msg_ready; slave is the deserializer.
interface ham_rx_deserializer_if;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_start;
    logic [6:0] message;
    logic       msg_valid;
    logic       msg_ready;
    logic       overflow;
    logic       frame_abort;

    modport master (
        output bit_in, bit_valid, frame_start, msg_ready,
        input  message, msg_valid, overflow, frame_abort
    );

    modport slave (
        input  bit_in, bit_valid, frame_start, msg_ready,
        output message, msg_valid, overflow, frame_abort
    );
endinterface

// File: rtl/ham_rx_deserializer.sv
// Collects 7-bit Hamming codewords from a serial stream into a 2-entry output FIFO.
// Define HAM_RX_DROP_CNT_EN to add a saturating drop_cnt output (dropped words + aborts).
module ham_rx_deserializer (
    input  logic                        clock,
    input  logic                        reset_L,
    ham_rx_deserializer_if.slave        bus
`ifdef HAM_RX_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic       abort_q, abort_d;
    logic       push;
    logic [6:0] push_word;

    logic [6:0] mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] occ_q, occ_d;
    logic       overflow_q;
    logic       pop, push_ok, drop;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        abort_d   = 1'b0;
        push      = 1'b0;
        push_word = shreg_q;
        unique case (state_q)
            StIdle: begin
                if (bus.bit_valid && bus.frame_start) begin
                    shreg_d    = 7'b0;
                    shreg_d[0] = bus.bit_in;
                    cnt_d      = 3'd1;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (bus.bit_valid) begin
                    if (bus.frame_start) begin
                        shreg_d    = 7'b0;
                        shreg_d[0] = bus.bit_in;
                        cnt_d      = 3'd1;
                        abort_d    = 1'b1;
                    end else if (cnt_q == 3'd6) begin
                        // Seventh bit goes straight into the FIFO on this edge.
                        push_word[6] = bus.bit_in;
                        push         = 1'b1;
                        cnt_d        = 3'd0;
                        state_d      = StIdle;
                    end else begin
                        shreg_d[cnt_q] = bus.bit_in;
                        cnt_d          = cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop     = (occ_q != 2'd0) && bus.msg_ready;
        push_ok = push && ((occ_q != 2'd2) || pop);
        drop    = push && (occ_q == 2'd2) && !pop;
        occ_d   = occ_q + {1'b0, push_ok} - {1'b0, pop};
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            shreg_q    <= 7'b0;
            abort_q    <= 1'b0;
            mem_q[0]   <= 7'b0;
            mem_q[1]   <= 7'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            abort_q <= abort_d;
            occ_q   <= occ_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.message     = mem_q[rd_ptr_q];
    assign bus.msg_valid   = (occ_q != 2'd0);
    assign bus.overflow    = overflow_q;
    assign bus.frame_abort = abort_q;

`ifdef HAM_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            drop_cnt_q <= 8'd0;
        end else if ((drop || abort_d) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ham_rx_deserializer.sv
// Randomized + directed bench for ham_rx_deserializer against a queue-based reference model.
module tb_ham_rx_deserializer;

    logic clock = 1'b0;
    logic reset_L;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clock = ~clock;

    ham_rx_deserializer_if ifc ();

`ifdef HAM_RX_DROP_CNT_EN
    logic [7:0] drop_cnt;
    int         m_drops;
    ham_rx_deserializer u_dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .bus      (ifc.slave),
        .drop_cnt (drop_cnt)
    );
`else
    ham_rx_deserializer u_dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (ifc.slave)
    );
`endif

    // Reference model: received bits of the current frame and the words awaiting pickup.
    bit         m_bits[$];
    logic [6:0] m_fifo[$];
    bit         m_ovf;
    bit         m_abort;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input bit b, input bit r, input bit rst);
        bit         do_pop;
        int         word;
        if (!rst) begin
            m_bits.delete();
            m_fifo.delete();
            m_ovf   = 0;
            m_abort = 0;
`ifdef HAM_RX_DROP_CNT_EN
            m_drops = 0;
`endif
            return;
        end
        do_pop  = (m_fifo.size() > 0) && r;
        m_abort = 0;
        if (v) begin
            if (s) begin
                if (m_bits.size() > 0) m_abort = 1;
                m_bits.delete();
                m_bits.push_back(b);
            end else if (m_bits.size() > 0) begin
                m_bits.push_back(b);
            end
        end
`ifdef HAM_RX_DROP_CNT_EN
        if (m_abort) m_drops++;
`endif
        if (do_pop) void'(m_fifo.pop_front());
        if (m_bits.size() == 7) begin
            word = 0;
            for (int i = 0; i < 7; i++) word += int'(m_bits[i]) * (1 << i);
            m_bits.delete();
            if (m_fifo.size() == 2) begin
                m_ovf = 1;
`ifdef HAM_RX_DROP_CNT_EN
                m_drops++;
`endif
            end else begin
                m_fifo.push_back(7'(word));
            end
        end
    endtask

    task automatic step(input bit v, input bit s, input bit b, input bit r, input bit rst);
        ifc.bit_valid   = v;
        ifc.frame_start = s;
        ifc.bit_in      = b;
        ifc.msg_ready   = r;
        reset_L         = rst;
        @(posedge clock);
        model_edge(v, s, b, r, rst);
        #1;
        check_eq("msg_valid", 32'(ifc.msg_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check_eq("message", 32'(ifc.message), 32'(m_fifo[0]));
        if (!rst) check_eq("message_rst", 32'(ifc.message), 32'd0);
        check_eq("overflow", 32'(ifc.overflow), 32'(m_ovf));
        check_eq("frame_abort", 32'(ifc.frame_abort), 32'(m_abort));
`ifdef HAM_RX_DROP_CNT_EN
        check_eq("drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
`endif
    endtask

    task automatic send_word(input logic [6:0] w, input bit r);
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, w[i], r, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] w;
        ifc.bit_valid   = 1'b0;
        ifc.frame_start = 1'b0;
        ifc.bit_in      = 1'b0;
        ifc.msg_ready   = 1'b0;
        reset_L         = 1'b0;
        do_reset();
        check_eq("rst_valid", 32'(ifc.msg_valid), 32'd0);
        check_eq("rst_overflow", 32'(ifc.overflow), 32'd0);

        // Bits 1,0,1,1,0,0,1 with msg_ready held high.
        w = 7'b1001101;
        send_word(w, 1'b1);
        check_eq("d28_valid", 32'(ifc.msg_valid), 32'd1);
        check_eq("d28_msg", 32'(ifc.message), 32'h4D);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("d28_popped", 32'(ifc.msg_valid), 32'd0);

        // Three back-to-back words with no reader: third dropped.
        send_word(7'h55, 1'b0);
        send_word(7'h2A, 1'b0);
        send_word(7'h7F, 1'b0);
        check_eq("d29_ovf", 32'(ifc.overflow), 32'd1);
        check_eq("d29_head0", 32'(ifc.message), 32'h55);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("d29_head1", 32'(ifc.message), 32'h2A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("d29_empty", 32'(ifc.msg_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("d29_ovf_sticky", 32'(ifc.overflow), 32'd1);

        // Partial word of four bits, then restart.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b1);
        w = 7'h33;
        step(1'b1, 1'b1, w[0], 1'b0, 1'b1);
        check_eq("d30_abort", 32'(ifc.frame_abort), 32'd1);
        for (int i = 1; i < 7; i++) step(1'b1, 1'b0, w[i], 1'b0, 1'b1);
        check_eq("d30_abort_off", 32'(ifc.frame_abort), 32'd0);
        check_eq("d30_msg", 32'(ifc.message), 32'h33);

        // Full FIFO, pop coincides with the seventh bit of a new word.
        do_reset();
        send_word(7'h11, 1'b0);
        send_word(7'h22, 1'b0);
        w = 7'h44;
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, w[i], 1'b0, 1'b1);
        step(1'b1, 1'b0, w[6], 1'b1, 1'b1);
        check_eq("d31_ovf", 32'(ifc.overflow), 32'd0);
        check_eq("d31_head", 32'(ifc.message), 32'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("d31_new", 32'(ifc.message), 32'h44);

        // Reset mid-word; subsequent bits without frame_start are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("d32_abort_rst", 32'(ifc.frame_abort), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("d32_valid", 32'(ifc.msg_valid), 32'd0);
        check_eq("d32_abort", 32'(ifc.frame_abort), 32'd0);

`ifdef HAM_RX_DROP_CNT_EN
        do_reset();
        send_word(7'h01, 1'b0);
        send_word(7'h02, 1'b0);
        send_word(7'h03, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("d33_three", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("d33_sat", 32'(drop_cnt), 32'hFF);
`endif

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(9) < 7), ($urandom_range(9) == 0), 1'($urandom),
                 1'($urandom), ($urandom_range(299) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ham_rx_deserializer.md
HAM_RX_DESERIALIZER -- requirements
Module: ham_rx_deserializer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; clock and reset_L are the only clock/reset ports.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_L  input  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-004 bit_in  input  1  serial codeword bit, sampled only when bit_valid=1.
REQ-005 bit_valid  input  1  qualifies bit_in for the current cycle.
REQ-006 frame_start  input  1  marks the current valid bit as bit 0 of a new codeword; ignored when bit_valid=0.
REQ-007 message  output  7  codeword at FIFO head; bit i is the i-th serial bit received; drives the Hamming(7,4) decoder input.
REQ-008 msg_valid  output  1  FIFO non-empty.
REQ-009 msg_ready  input  1  downstream accepts the head; a pop occurs when msg_valid&&msg_ready.
REQ-010 overflow  output  1  sticky flag: a completed codeword was dropped.
REQ-011 frame_abort  output  1  one-cycle pulse: a partial codeword was discarded.

Function
REQ-012 Collection SHALL use a two-state FSM: IDLE (no partial word) and SHIFT (1-6 bits held), plus a 3-bit bit counter.
REQ-013 In IDLE, a valid bit with frame_start=1 SHALL be stored as bit 0 and the FSM SHALL move to SHIFT with count=1; a valid bit with frame_start=0 SHALL be ignored.
REQ-014 In SHIFT, a valid bit with frame_start=0 SHALL be stored at position count, and count SHALL increment.
REQ-015 When the 7th bit is stored, the word SHALL be pushed to the FIFO in the same edge, and the FSM SHALL return to IDLE with count=0.
REQ-016 In SHIFT, a valid bit with frame_start=1 SHALL discard the partial word, pulse frame_abort for the next cycle, and restart at bit 0 with count=1.
REQ-017 Cycles with bit_valid=0 SHALL hold all collection state; there is no timeout.
REQ-018 The output buffer SHALL be a 2-entry FIFO; message SHALL reflect the head entry combinationally from registers, and latency from the 7th valid bit edge to msg_valid=1 SHALL be one cycle when the FIFO is empty.
REQ-019 msg_valid, once high, SHALL stay high, and message SHALL stay stable until popped.
REQ-020 A push with the FIFO full and no pop in the same cycle SHALL drop the new word, set overflow, and leave FIFO contents unchanged.
REQ-021 A simultaneous push and pop with the FIFO full SHALL succeed with no overflow; with the FIFO empty, a pop is impossible and the push SHALL land.
REQ-022 FIFO pointers SHALL wrap modulo 2; occupancy SHALL be held in a 2-bit count with range 0-2.
REQ-023 overflow SHALL remain 1 until reset.

Reset
REQ-024 While reset_L=0 at a clock edge: FSM=IDLE, count=0, FIFO empty, msg_valid=0, message=7'b0, overflow=0, frame_abort=0.
REQ-025 A reset asserted mid-codeword SHALL discard the partial word without a frame_abort pulse; after reset, the first valid bit is honoured only if frame_start=1.

Configuration
REQ-026 When macro HAM_RX_DROP_CNT_EN is defined, the block SHALL add output drop_cnt [7:0], which increments on every dropped word (REQ-020) and every frame_abort, saturates at 8'hFF, and resets to 0.
REQ-027 When HAM_RX_DROP_CNT_EN is not defined, the drop_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Sequence of bits 1,0,1,1,0,0,1 with frame_start on the first bit and msg_ready=1 -> one cycle after the 7th bit, msg_valid=1 and message=7'b1001101, popped the same cycle.
REQ-029 Three codewords 7'h55, 7'h2A, 7'h7F sent back-to-back with msg_ready=0 -> first two held in order, third dropped, overflow=1; with msg_ready=1 the bench then reads 7'h55, then 7'h2A, then msg_valid=0.
REQ-030 Four bits sent, then frame_start=1 on the next valid bit -> frame_abort pulses once; the next 7 bits form the output word, and the partial bits never appear on message.
REQ-031 FIFO full, with msg_ready=1 held while a new 7th bit arrives -> head advances, new word enters, overflow stays 0.
REQ-032 reset_L=0 after bit 3 of a word, then a valid bit without frame_start -> bit ignored, msg_valid=0, frame_abort=0.
REQ-033 With HAM_RX_DROP_CNT_EN defined, one overflow plus two aborts -> drop_cnt=3; 300 drops -> drop_cnt=8'hFF.
